// File: rtl/rv32i_types.sv
// ============================================================================
// Module   : rv32i_types (package)
// Brief    : Shared RV32I types for the front end: machine word, base opcodes,
//            fetch FSM state encoding and immediate-extraction helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    // Architectural machine word
    typedef logic [31:0] rv32i_word;

    // RV32I base opcodes (inst[6:0])
    typedef enum logic [6:0] {
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111,
        OP_JAL   = 7'b1101111,
        OP_JALR  = 7'b1100111,
        OP_BR    = 7'b1100011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011,
        OP_IMM   = 7'b0010011,
        OP_REG   = 7'b0110011,
        OP_CSR   = 7'b1110011
    } rv32i_opcode;

    // Fetch FSM states, explicitly 2-bit encoded
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    // Sequential fetch stride in bytes
    localparam rv32i_word INST_BYTES = 32'd4;

    // J-type immediate, sign-extended, byte offset
    function automatic rv32i_word imm_j(input rv32i_word inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended, byte offset
    function automatic rv32i_word imm_b(input rv32i_word inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_predecode.sv
// ============================================================================
// Module   : fetch_predecode
// Brief    : Combinational predecode of a fetched word. Produces the predicted
//            next PC and a taken flag. Static prediction (JAL always taken,
//            backward conditional branches taken) is built only when the
//            FETCH_STATIC_PRED_EN macro is defined; otherwise every word falls
//            through to pc+4 with no prediction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_predecode
    import rv32i_types::*;
(
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        br_pred_o
);

    // Fall-through address; wraps modulo 2^32
    logic [31:0] w_pc_seq;
    assign w_pc_seq = pc_i + INST_BYTES;

`ifdef FETCH_STATIC_PRED_EN
    logic [6:0] w_opcode;
    assign w_opcode = inst_i[6:0];

    // Static prediction: JAL taken, backward branch taken, everything else sequential
    always_comb begin
        pc_next_o = w_pc_seq;
        br_pred_o = 1'b0;
        if (w_opcode == OP_JAL) begin
            pc_next_o = pc_i + imm_j(inst_i);
            br_pred_o = 1'b1;
        end else if ((w_opcode == OP_BR) && inst_i[31]) begin
            // inst[31] is the sign of imm_b: negative offset means a loop back-edge
            pc_next_o = pc_i + imm_b(inst_i);
            br_pred_o = 1'b1;
        end
    end
`else
    // Instruction word is not inspected without static prediction
    logic w_unused_inst;
    assign w_unused_inst = ^inst_i;

    assign pc_next_o = w_pc_seq;
    assign br_pred_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : Front-end fetch stage. Holds the PC, issues single-word I-cache
//            reads, predecodes each returned word and offers
//            {inst, pc, pc_next, br_pred} to the instruction queue. A flush
//            redirects the PC; a read already in flight is drained in DISCARD
//            and its data dropped.
//            Optional static branch prediction: define FETCH_STATIC_PRED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        icache_read,
    output logic [31:0] icache_address,
    input  logic [31:0] icache_rdata,
    input  logic        icache_resp,
    input  logic        iq_ready,
    output logic        iq_valid,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic [31:0] iq_pc_next,
    output logic        iq_br_pred
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;        // architectural fetch PC
    logic [31:0]  faddr_q;     // address presented to the cache; frozen while a read is open
    logic         read_q;
    logic [31:0]  inst_q;
    logic [31:0]  ipc_q;
    logic [31:0]  ipc_next_q;
    logic         br_pred_q;

    logic [31:0]  w_pred_next;
    logic         w_pred_taken;
    logic         w_transfer;

    // Predecode works on the raw response against the PC of the open read
    fetch_predecode u_predecode (
        .inst_i    (icache_rdata),
        .pc_i      (pc_q),
        .pc_next_o (w_pred_next),
        .br_pred_o (w_pred_taken)
    );

    // A queue write happens only from HOLD, and a flush suppresses it that cycle
    assign w_transfer = (state_q == HOLD) && iq_ready && !flush;

    assign iq_valid       = w_transfer;
    assign icache_read    = read_q;
    assign icache_address = faddr_q;
    assign iq_inst        = inst_q;
    assign iq_pc          = ipc_q;
    assign iq_pc_next     = ipc_next_q;
    assign iq_br_pred     = br_pred_q;

    // Fetch FSM with PC, fetch-address and queue-entry registers; flush has top priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            faddr_q    <= RESET_PC;
            read_q     <= 1'b0;
            inst_q     <= 32'd0;
            ipc_q      <= 32'd0;
            ipc_next_q <= 32'd0;
            br_pred_q  <= 1'b0;
        end else if (flush) begin
            pc_q <= redirect_pc;
            case (state_q)
                REQ, DISCARD: begin
                    if (icache_resp) begin
                        // Outstanding read closes this cycle: start the redirected read now
                        state_q <= REQ;
                        faddr_q <= redirect_pc;
                        read_q  <= 1'b1;
                    end else begin
                        // Read still open: keep the stale address until it completes
                        state_q <= DISCARD;
                        read_q  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE or HOLD: no read open, the held entry is dropped
                    state_q <= REQ;
                    faddr_q <= redirect_pc;
                    read_q  <= 1'b1;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    faddr_q <= pc_q;
                    read_q  <= 1'b1;
                end
                REQ: begin
                    if (icache_resp) begin
                        state_q    <= HOLD;
                        read_q     <= 1'b0;
                        inst_q     <= icache_rdata;
                        ipc_q      <= pc_q;
                        ipc_next_q <= w_pred_next;
                        br_pred_q  <= w_pred_taken;
                    end
                end
                HOLD: begin
                    if (iq_ready) begin
                        state_q <= REQ;
                        pc_q    <= ipc_next_q;
                        faddr_q <= ipc_next_q;
                        read_q  <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (icache_resp) begin
                        // Stale data dropped; reissue at the redirected PC
                        state_q <= REQ;
                        faddr_q <= pc_q;
                        read_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    read_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        icache_read;
    logic [31:0] icache_address;
    logic [31:0] icache_rdata;
    logic        icache_resp;
    logic        iq_ready;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic [31:0] iq_pc_next;
    logic        iq_br_pred;

    int vectors;
    int miscompares;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ADDI     = 32'h0010_0093;
    localparam logic [31:0] ADDI2    = 32'h0020_0113;
    localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;
    localparam logic [31:0] BEQ_M16  = 32'hFE00_08E3;   // beq x0,x0,-16
    localparam logic [31:0] JAL_P40  = 32'h0400_006F;   // jal x0,+0x40
    localparam logic [31:0] BNE_P8   = 32'h0000_1463;   // bne x0,x0,+8
    localparam logic [31:0] JALR_0   = 32'h0000_00E7;   // jalr x1,0(x0)
    localparam logic [31:0] JAL_P8   = 32'h0080_006F;   // jal x0,+8

    fetch_unit #(.RESET_PC(32'h0000_0060)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .iq_ready       (iq_ready),
        .iq_valid       (iq_valid),
        .iq_inst        (iq_inst),
        .iq_pc          (iq_pc),
        .iq_pc_next     (iq_pc_next),
        .iq_br_pred     (iq_br_pred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // From a REQ window: redirect with a same-cycle response so the next read goes to addr
    task automatic fetch_at(input logic [31:0] addr);
        flush = 1'b1; redirect_pc = addr; icache_resp = 1'b1; icache_rdata = JUNK;
        cycle();
        flush = 1'b0; icache_resp = 1'b0;
        chk("redir_read", {31'd0, icache_read}, 32'd1);
        chk("redir_addr", icache_address, addr);
    endtask

    // From a REQ window: return inst, check the queue entry, accept it, check next address
    task automatic deliver(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] nxt, input logic pred);
        icache_resp = 1'b1; icache_rdata = inst;
        cycle();
        icache_resp = 1'b0; icache_rdata = JUNK;
        chk({tag, "_valid"}, {31'd0, iq_valid}, 32'd1);
        chk({tag, "_inst"}, iq_inst, inst);
        chk({tag, "_pc"}, iq_pc, pc);
        chk({tag, "_pcnext"}, iq_pc_next, nxt);
        chk({tag, "_pred"}, {31'd0, iq_br_pred}, {31'd0, pred});
        cycle();
        chk({tag, "_nextaddr"}, icache_address, nxt);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b0; flush = 1'b0; redirect_pc = 32'd0;
        icache_rdata = 32'd0; icache_resp = 1'b0; iq_ready = 1'b1;

        // Reset state
        cycle(); cycle();
        chk("rst_read",  {31'd0, icache_read}, 32'd0);
        chk("rst_valid", {31'd0, iq_valid}, 32'd0);
        chk("rst_inst",  iq_inst, 32'd0);
        chk("rst_pc",    iq_pc, 32'd0);
        chk("rst_pcnext", iq_pc_next, 32'd0);
        chk("rst_pred",  {31'd0, iq_br_pred}, 32'd0);

        // 1: first read one cycle after release, then one instruction every 2 cycles
        rst = 1'b1;
        cycle();
        chk("t1_read0", {31'd0, icache_read}, 32'd1);
        chk("t1_addr0", icache_address, 32'h60);
        icache_resp = 1'b1; icache_rdata = NOP;
        chk("t1_novalid_req", {31'd0, iq_valid}, 32'd0);
        cycle();
        icache_resp = 1'b0;
        chk("t1_hold_read", {31'd0, icache_read}, 32'd0);
        chk("t1_valid0", {31'd0, iq_valid}, 32'd1);
        chk("t1_pc0", iq_pc, 32'h60);
        chk("t1_next0", iq_pc_next, 32'h64);
        cycle();
        chk("t1_addr1", icache_address, 32'h64);
        chk("t1_valid_gap", {31'd0, iq_valid}, 32'd0);
        icache_resp = 1'b1; icache_rdata = ADDI;
        cycle();
        icache_resp = 1'b0;
        chk("t1_valid1", {31'd0, iq_valid}, 32'd1);
        chk("t1_pc1", iq_pc, 32'h64);
        chk("t1_inst1", iq_inst, ADDI);
        cycle();
        chk("t1_addr2", icache_address, 32'h68);

        // 2: queue back-pressure in HOLD
        icache_resp = 1'b1; icache_rdata = ADDI2;
        cycle();
        icache_resp = 1'b0; icache_rdata = JUNK;
        iq_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_valid", {31'd0, iq_valid}, 32'd0);
            chk("t2_read", {31'd0, icache_read}, 32'd0);
            chk("t2_pc", iq_pc, 32'h68);
            chk("t2_inst", iq_inst, ADDI2);
            cycle();
        end
        iq_ready = 1'b1;
        #1;
        chk("t2_resume_valid", {31'd0, iq_valid}, 32'd1);
        cycle();
        chk("t2_resume_addr", icache_address, 32'h6C);

        // 3: flush in REQ without response, response 3 cycles later
        flush = 1'b1; redirect_pc = 32'h200;
        #1;
        chk("t3_flush_valid", {31'd0, iq_valid}, 32'd0);
        cycle();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t3_disc_read", {31'd0, icache_read}, 32'd1);
            chk("t3_disc_addr", icache_address, 32'h6C);
            chk("t3_disc_valid", {31'd0, iq_valid}, 32'd0);
            cycle();
        end
        chk("t3_disc_addr2", icache_address, 32'h6C);
        icache_resp = 1'b1; icache_rdata = JAL_P40;
        cycle();
        icache_resp = 1'b0;
        chk("t3_req_read", {31'd0, icache_read}, 32'd1);
        chk("t3_req_addr", icache_address, 32'h200);
        chk("t3_req_valid", {31'd0, iq_valid}, 32'd0);
        deliver("t3_fetch", NOP, 32'h200, 32'h204, 1'b0);

        // 4/5: predecode, expectations depend on the build
        fetch_at(32'h100);
`ifdef FETCH_STATIC_PRED_EN
        deliver("t4_beq", BEQ_M16, 32'h100, 32'h0F0, 1'b1);
        fetch_at(32'h100);
        deliver("t4_jal", JAL_P40, 32'h100, 32'h140, 1'b1);
`else
        deliver("t5_beq", BEQ_M16, 32'h100, 32'h104, 1'b0);
        fetch_at(32'h100);
        deliver("t5_jal", JAL_P40, 32'h100, 32'h104, 1'b0);
`endif
        fetch_at(32'h100);
        deliver("t4_bne", BNE_P8, 32'h100, 32'h104, 1'b0);
        fetch_at(32'h100);
        deliver("t4_jalr", JALR_0, 32'h100, 32'h104, 1'b0);

        // 6: wrap-around and asynchronous reset mid-read
        fetch_at(32'hFFFF_FFFC);
`ifdef FETCH_STATIC_PRED_EN
        deliver("t6_jal_wrap", JAL_P8, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1);
`else
        deliver("t6_seq_wrap", JAL_P8, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);
`endif
        chk("t6_req_read", {31'd0, icache_read}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_read", {31'd0, icache_read}, 32'd0);
        chk("t6_async_pc", iq_pc, 32'd0);
        chk("t6_async_inst", iq_inst, 32'd0);
        cycle();
        rst = 1'b1;
        cycle();
        chk("t6_restart_read", {31'd0, icache_read}, 32'd1);
        chk("t6_restart_addr", icache_address, 32'h60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
